sample_delay_line: RTL and testbench

Per-channel programmable sample delay and attenuation stage. It sits directly downstream of the 16-bit sample source and consumes one signed sample per sample strobe, one strobe per `SoundPeri`. It stores samples in a ring buffer and emits each sample delayed by a programmable number of sample periods and arithmetically attenuated. The surround mixer instantiates one per output channel to build inter-channel delay and level differences.

---
 rtl/sample_delay_line.sv | 118 +++++++++++
 tb/tb_sample_delay_line.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sample_delay_line.sv
// Per-channel programmable sample delay with arithmetic attenuation.
// Samples go into a ring buffer; each strobe emits one delayed, right-shifted sample one clock later.
module sample_delay_line #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [ADDR_W-1:0] delay,
  input  logic [3:0]        atten,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid,
  output logic              primed
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]          fill_q, fill_d;
  logic [DATA_W-1:0]        out_q, out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     primed_q, primed_d;
  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        rd_addr_s;
  logic [ADDR_W:0]          delay_ext_s;
  logic signed [DATA_W-1:0] sel_s;

  // Sample selection, pointer/fill update and output datapath
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    rd_addr_s   = wr_ptr_q - delay;
    delay_ext_s = {1'b0, delay};

    // Zero delay bypasses the memory; entries beyond the fill level are stale and read as zero.
    if (delay == {ADDR_W{1'b0}}) begin
      sel_s = $signed(sample_in);
    end else if (delay_ext_s <= fill_q) begin
      sel_s = $signed(mem_q[rd_addr_s]);
    end else begin
      sel_s = {DATA_W{1'b0}};
    end

    if (sample_valid) begin
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
      fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + (ADDR_W + 1)'(1);
      out_d       = DATA_W'(sel_s >>> atten);
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Priming state machine: RUN once the buffer covers the requested delay
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (sample_valid && (fill_q >= delay_ext_s)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RUN: begin
        if (sample_valid && (delay_ext_s > fill_q)) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_FILL;
    endcase
    primed_d = (state_d == ST_RUN);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {ADDR_W{1'b0}};
      fill_q      <= {(ADDR_W + 1){1'b0}};
      out_q       <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      state_q     <= ST_FILL;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
      state_q     <= state_d;
    end
  end

  // Ring-buffer storage; contents survive reset, the fill count masks them
  always_ff @(posedge clk) begin
    if (!rst && sample_valid) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign sample_out = out_q;
  assign out_valid  = out_valid_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_sample_delay_line.sv
// Bench for sample_delay_line: a 64-deep and an 8-deep instance, checked against a sample-history model.
module tb_sample_delay_line;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        valid [2];
  logic [15:0] din   [2];
  logic [5:0]  dly   [2];
  logic [3:0]  att   [2];
  logic [15:0] dout  [2];
  logic        ovld  [2];
  logic        prim  [2];

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model: full history of samples written since reset
  logic [15:0] hist [2][4096];
  int          cnt  [2];
  logic [15:0] exp_out [2];
  logic        exp_v   [2];
  logic        exp_p   [2];
  int          cur_dly [2];

  always #5 clk = ~clk;

  sample_delay_line #(.DATA_W(16), .ADDR_W(6)) dut_a (
    .clk(clk), .rst(rst[0]), .sample_in(din[0]), .sample_valid(valid[0]),
    .delay(dly[0]), .atten(att[0]), .sample_out(dout[0]), .out_valid(ovld[0]), .primed(prim[0])
  );

  sample_delay_line #(.DATA_W(16), .ADDR_W(3)) dut_b (
    .clk(clk), .rst(rst[1]), .sample_in(din[1]), .sample_valid(valid[1]),
    .delay(dly[1][2:0]), .atten(att[1]), .sample_out(dout[1]), .out_valid(ovld[1]), .primed(prim[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model update on each clock edge from the inputs presented
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int depth;
      int k;
      logic signed [15:0] sel;
      depth = (d == 0) ? 64 : 8;
      if (rst[d]) begin
        cnt[d] = 0; exp_out[d] = 16'h0000; exp_v[d] = 1'b0; exp_p[d] = 1'b0;
      end else if (valid[d]) begin
        if (dly[d] == 6'd0) sel = din[d];
        else if (int'(dly[d]) <= cnt[d]) sel = hist[d][cnt[d] - int'(dly[d])];
        else sel = 16'sh0000;
        k = (cnt[d] < depth) ? cnt[d] : depth;
        if (!exp_p[d] && k >= int'(dly[d])) exp_p[d] = 1'b1;
        else if (exp_p[d] && int'(dly[d]) > k) exp_p[d] = 1'b0;
        hist[d][cnt[d]] = din[d];
        cnt[d] = cnt[d] + 1;
        exp_out[d] = sel >>> att[d];
        exp_v[d] = 1'b1;
      end else begin
        exp_v[d] = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_out[%0d]", d), {16'h0, dout[d]}, {16'h0, exp_out[d]});
        chk($sformatf("model_valid[%0d]", d), {31'h0, ovld[d]}, {31'h0, exp_v[d]});
        chk($sformatf("model_primed[%0d]", d), {31'h0, prim[d]}, {31'h0, exp_p[d]});
      end
    end
  end

  task automatic cyc(input int d, input logic v, input logic [15:0] val, input logic [5:0] dl, input logic [3:0] at);
    valid[0] = 1'b0; valid[1] = 1'b0;
    valid[d] = v; din[d] = val; dly[d] = dl; att[d] = at;
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    valid[0] = 1'b0; valid[1] = 1'b0;
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
  endtask

  task automatic chk_lit(input string name, input int d, input logic [15:0] o, input logic v, input logic p);
    chk({name, "_out"}, {16'h0, dout[d]}, {16'h0, o});
    chk({name, "_valid"}, {31'h0, ovld[d]}, {31'h0, v});
    chk({name, "_primed"}, {31'h0, prim[d]}, {31'h0, p});
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; valid[d] = 1'b0; din[d] = 16'h0; dly[d] = 6'd0; att[d] = 4'd0; cur_dly[d] = 0;
    end
    @(negedge clk); @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    cmp_en = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'b0, 16'h0, 6'd0, 4'd0);
      chk_lit("idle", 0, 16'h0000, 1'b0, 1'b0);
    end

    // Zero-delay passthrough
    cyc(0, 1'b1, 16'h1234, 6'd0, 4'd0);
    chk_lit("bypass1", 0, 16'h1234, 1'b1, 1'b1);
    cyc(0, 1'b1, 16'h8000, 6'd0, 4'd0);
    chk_lit("bypass2", 0, 16'h8000, 1'b1, 1'b1);
    cyc(0, 1'b0, 16'h0, 6'd0, 4'd0);
    chk_lit("hold", 0, 16'h8000, 1'b0, 1'b1);

    // Delay 3 ramp
    do_reset(0);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 1'b1, 16'(i), 6'd3, 4'd0);
      chk_lit("ramp", 0, (i <= 3) ? 16'h0 : 16'(i - 3), 1'b1, (i >= 4));
    end

    // Small buffer, maximum delay, two wraps
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1'b1, 16'(100 + i), 6'd7, 4'd0);
      chk_lit("wrap", 1, (i < 7) ? 16'h0 : 16'(93 + i), 1'b1, (i >= 7));
    end

    // Attenuation
    cyc(0, 1'b1, 16'hFFFB, 6'd0, 4'd2);
    chk({"att2", ""}, {16'h0, dout[0]}, 32'h0000FFFE);
    cyc(0, 1'b1, 16'h7FFF, 6'd0, 4'd15);
    chk("att15_pos", {16'h0, dout[0]}, 32'h00000000);
    cyc(0, 1'b1, 16'h8000, 6'd0, 4'd15);
    chk("att15_neg", {16'h0, dout[0]}, 32'h0000FFFF);

    // Reset mid-stream and delay raise before saturation
    do_reset(0);
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 16'(10 + i), 6'd2, 4'd0);
    chk_lit("run", 0, 16'd10, 1'b1, 1'b1);
    do_reset(0);
    chk_lit("midrst", 0, 16'h0, 1'b0, 1'b0);
    cyc(0, 1'b1, 16'd7, 6'd2, 4'd0); chk_lit("re1", 0, 16'd0, 1'b1, 1'b0);
    cyc(0, 1'b1, 16'd8, 6'd2, 4'd0); chk_lit("re2", 0, 16'd0, 1'b1, 1'b0);
    cyc(0, 1'b1, 16'd9, 6'd2, 4'd0); chk_lit("re3", 0, 16'd7, 1'b1, 1'b1);
    cyc(0, 1'b1, 16'd10, 6'd2, 4'd0); chk_lit("re4", 0, 16'd8, 1'b1, 1'b1);
    cyc(0, 1'b1, 16'd11, 6'd5, 4'd0); chk_lit("raise1", 0, 16'd0, 1'b1, 1'b0);
    cyc(0, 1'b1, 16'd12, 6'd5, 4'd0); chk_lit("raise2", 0, 16'd7, 1'b1, 1'b1);

    // Randomized traffic on both instances
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d]   = ($urandom_range(0, 99) == 0);
        valid[d] = ($urandom_range(0, 9) < 7);
        din[d]   = 16'($urandom);
        if ($urandom_range(0, 19) == 0)
          cur_dly[d] = (d == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
        dly[d] = 6'(cur_dly[d]);
        att[d] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      end
      @(negedge clk);
    end
    rst[0] = 1'b0; rst[1] = 1'b0; valid[0] = 1'b0; valid[1] = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
